// File: rtl/gearbox_lane_sched.sv
// gearbox_lane_sched: round-robin burst scheduler feeding one gearbox input.
// A grant lasts BURST blocks; starved bursts are padded with IDLE_BLOCK to keep gearbox period alignment.
module gearbox_lane_sched #(
  parameter int NUM_REQ = 4,
  parameter int DW = 132,
  parameter int BURST = 32,
  parameter int STALL_MAX = 16,
  parameter logic [DW-1:0] IDLE_BLOCK = {4'h1, 128'h0}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [DW-1:0]         gb_din,
  output logic                  gb_din_valid,
  input  logic                  gb_din_ready,
  output logic                  grant_active,
  output logic [2:0]            grant_id,
  output logic [4:0]            blk_cnt,
  output logic [15:0]           pad_cnt
);
  localparam int SW = $clog2(STALL_MAX + 1);
  typedef enum logic [1:0] {S_IDLE, S_BURST, S_PAD} state_t;
  state_t state_q, state_d;
  logic [2:0] grant_q, grant_d, sel;
  logic [4:0] blk_q, blk_d;
  logic [15:0] pad_q, pad_d;
  logic [SW-1:0] stall_q, stall_d, stall_inc;
  logic found, g_valid, last, thresh;
  logic [DW-1:0] g_data;
  always_comb begin
    found = 1'b0;
    sel = grant_q;
    g_valid = 1'b0;
    g_data = '0;
    req_ready = '0;
    // search starts just after the last grant, so every requester gets a turn
    for (int k = 1; k <= NUM_REQ; k++)
      for (int i = 0; i < NUM_REQ; i++)
        if (!found && req_valid[i] && i == (int'(grant_q) + k) % NUM_REQ) begin
          found = 1'b1;
          sel = 3'(i);
        end
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q == 3'(i)) begin
        g_valid = req_valid[i];
        g_data = req_data[i*DW +: DW];
        req_ready[i] = (state_q == S_BURST) && gb_din_ready;
      end
    stall_inc = stall_q + 1'b1;
    thresh = int'(stall_inc) >= STALL_MAX;
    last = blk_q == 5'(BURST - 1);
    state_d = state_q;
    grant_d = grant_q;
    blk_d = blk_q;
    pad_d = pad_q;
    stall_d = stall_q;
    gb_din = '0;
    gb_din_valid = 1'b0;
    case (state_q)
      S_IDLE: if (enable && found) begin
        grant_d = sel;
        state_d = S_BURST;
      end
      S_BURST: begin
        gb_din = g_data;
        gb_din_valid = g_valid;
        if (gb_din_ready && g_valid) begin
          stall_d = '0;
          blk_d = last ? '0 : blk_q + 1'b1;
          state_d = last ? S_IDLE : S_BURST;
        end else if (gb_din_ready) begin
          stall_d = thresh ? '0 : stall_inc;
          state_d = thresh ? S_PAD : S_BURST;
        end
      end
      S_PAD: begin
        gb_din = IDLE_BLOCK;
        gb_din_valid = 1'b1;
        if (gb_din_ready) begin
          blk_d = last ? '0 : blk_q + 1'b1;
          pad_d = &pad_q ? pad_q : pad_q + 1'b1;
          state_d = last ? S_IDLE : S_PAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 3'(NUM_REQ - 1);
      blk_q <= '0;
      pad_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      blk_q <= blk_d;
      pad_q <= pad_d;
      stall_q <= stall_d;
    end
  end
  assign grant_active = state_q != S_IDLE;
  assign grant_id = grant_q;
  assign blk_cnt = blk_q;
  assign pad_cnt = pad_q;
endmodule
